execute_stage: RTL

Registered execute stage of the RISC-V integer pipeline. It sits directly downstream of the ALU control decoder and operand-select logic. It accepts one decoded instruction per cycle over a valid/ready handshake, evaluates the ALU operation and the branch condition, and holds the result in the EX/MEM register for the memory stage. Backpressure from memory and flush from branch/trap redirect are handled inside this block.

---
 rtl/execute_stage_pkg.sv | 27 ++
 rtl/execute_stage_alu.sv | 39 +++
 rtl/execute_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the integer pipeline: ALU operation codes and
// branch-condition funct3 values used by decode and execute.
package execute_stage_pkg;

  localparam int ALU_CTRL_W = 4;

  // ALU operation codes; codes 10..15 are undefined and flag illegal_op.
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd9;

  // Branch condition select (funct3 of the B-type instruction).
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

endpackage

// File: rtl/execute_stage_alu.sv
// Purely combinational integer ALU with an illegal-operation flag.
module alu_core
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  output logic [XLEN-1:0]       result,
  output logic                  illegal
);

  // Shifts only ever use the low five bits of the second operand.
  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  // Operation select; undefined codes return zero and raise the flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Registered execute stage: ALU, branch resolution and the EX/MEM register
// behind a valid/ready handshake, with flush from redirect.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [2:0]            funct3,
  input  logic                  is_branch,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [4:0]            rd,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [XLEN-1:0]       store_data,
  output logic [4:0]            out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  branch_taken,
  output logic [XLEN-1:0]       branch_target,
  output logic                  illegal_op
);

  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;
  logic            branch_cond;
  logic            accept;

  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] store_data_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic            illegal_q;

  alu_core #(.XLEN(XLEN)) u_alu (
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (alu_result),
    .illegal     (alu_illegal)
  );

  // Branch condition from the raw register values.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      FUNCT3_BEQ:  branch_cond = (rs1_val == rs2_val);
      FUNCT3_BNE:  branch_cond = (rs1_val != rs2_val);
      FUNCT3_BLT:  branch_cond = ($signed(rs1_val) <  $signed(rs2_val));
      FUNCT3_BGE:  branch_cond = ($signed(rs1_val) >= $signed(rs2_val));
      FUNCT3_BLTU: branch_cond = (rs1_val <  rs2_val);
      FUNCT3_BGEU: branch_cond = (rs1_val >= rs2_val);
      default:     branch_cond = 1'b0;
    endcase
  end

  // The slot frees up either when empty or when its entry drains this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // EX/MEM register: flush kills, accept loads, otherwise hold or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, because reset values of
    // result, store_data and branch_target are visible at the outputs.
    if (!rst_n) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        result_q     <= alu_result;
        store_data_q <= rs2_val;
        rd_q         <= rd;
        reg_write_q  <= reg_write;
        mem_read_q   <= mem_read;
        mem_write_q  <= mem_write;
        taken_q      <= is_branch && branch_cond;
        target_q     <= pc + imm;
        illegal_q    <= alu_illegal;
      end
    end
  end

  assign out_valid     = valid_q;
  assign result        = result_q;
  assign store_data    = store_data_q;
  assign out_rd        = rd_q;
  assign branch_target = target_q;
  assign illegal_op    = illegal_q;

  // Side-effecting controls never escape without a valid entry.
  assign out_reg_write = valid_q && reg_write_q;
  assign out_mem_read  = valid_q && mem_read_q;
  assign out_mem_write = valid_q && mem_write_q;
  assign branch_taken  = valid_q && taken_q;

endmodule
